ysyx_22041752_mem_arbiter: RTL and testbench

Two-requester arbiter sharing one single-port memory channel between instruction fetch (IF stage) and load/store (LS stage). It accepts one request per side with a req/ready handshake, serialises them onto the memory port with round-robin priority, and returns each response to its owner. A one-entry pending slot buffers the losing side of a simultaneous request. Pipeline flushes cancel stale instruction responses.

---
 rtl/ysyx_22041752_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_ysyx_22041752_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041752_mem_arbiter.sv
// ysyx_22041752_mem_arbiter
//
// Shares one single-port memory channel between instruction fetch (IF) and
// load/store (LS). Each side hands over one request with an en/ready
// handshake. Requests go to memory one at a time with round-robin priority,
// and each response is routed back to the side that issued it. When both
// sides ask in the same cycle, the loser is parked in a one-entry pending
// slot. A flush suppresses stale fetch responses and drops a parked fetch.
//
// Ports
//   clk, reset        : clock (rising edge), asynchronous active-low reset
//   inst_en/addr      : fetch request; inst_ready = can accept a fetch
//   inst_rvalid/rdata : fetch response pulse and data (rdata = mem_rdata)
//   data_en/wr/addr   : load/store request (wr=1 store)
//   data_wdata/wstrb  : store data and byte enables
//   data_ready        : can accept a load/store
//   data_rvalid/rdata : load data or store acknowledge pulse
//   flush             : pipeline flush, kills earlier fetches
//   mem_req           : memory request, held until mem_gnt
//   mem_wr/addr/wdata/wstrb : registered request payload
//   mem_gnt           : memory accepted the request
//   mem_resp/rdata    : memory response, one per grant
module ysyx_22041752_mem_arbiter #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inst_en,
  input  logic [ADDR_WD-1:0]     inst_addr,
  output logic                   inst_ready,
  output logic                   inst_rvalid,
  output logic [DATA_WD-1:0]     inst_rdata,
  input  logic                   data_en,
  input  logic                   data_wr,
  input  logic [ADDR_WD-1:0]     data_addr,
  input  logic [DATA_WD-1:0]     data_wdata,
  input  logic [DATA_WD/8-1:0]   data_wstrb,
  output logic                   data_ready,
  output logic                   data_rvalid,
  output logic [DATA_WD-1:0]     data_rdata,
  input  logic                   flush,
  output logic                   mem_req,
  output logic                   mem_wr,
  output logic [ADDR_WD-1:0]     mem_addr,
  output logic [DATA_WD-1:0]     mem_wdata,
  output logic [DATA_WD/8-1:0]   mem_wstrb,
  input  logic                   mem_gnt,
  input  logic                   mem_resp,
  input  logic [DATA_WD-1:0]     mem_rdata
);

  localparam int STRB_WD = DATA_WD / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  logic [1:0]         state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_gnt_q, last_gnt_d;
  logic               kill_q, kill_d;
  logic               pend_v_q, pend_v_d;
  logic               pend_owner_q, pend_owner_d;
  logic               pend_wr_q, pend_wr_d;
  logic [ADDR_WD-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_WD-1:0] pend_wdata_q, pend_wdata_d;
  logic [STRB_WD-1:0] pend_wstrb_q, pend_wstrb_d;
  logic               mem_wr_q, mem_wr_d;
  logic [ADDR_WD-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WD-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_WD-1:0] mem_wstrb_q, mem_wstrb_d;

  logic idle_free;
  logic inst_take;
  logic data_take;
  logic pick_data;
  logic resp_fire;
  logic pend_drop;

  // Ready is forced low while reset is held, even though the state register
  // already reads IDLE during reset.
  assign idle_free  = (state_q == S_IDLE) && !pend_v_q;
  assign inst_ready = reset && idle_free;
  assign data_ready = reset && idle_free;

  assign inst_take = inst_en && inst_ready;
  assign data_take = data_en && data_ready;

  // On a tie the side that was not issued last wins.
  assign pick_data = data_take && (!inst_take || (last_gnt_q == OWN_INST));

  assign resp_fire = (state_q == S_WAIT) && mem_resp;

  // A flush discards a parked fetch before it ever reaches memory.
  assign pend_drop = pend_v_q && flush && (pend_owner_q == OWN_INST);

  // A fetch response is stale if a flush was seen earlier in its lifetime
  // or arrives alongside the response itself.
  assign inst_rvalid = resp_fire && (owner_q == OWN_INST) && !kill_q && !flush;
  assign data_rvalid = resp_fire && (owner_q == OWN_DATA);
  assign inst_rdata  = mem_rdata;
  assign data_rdata  = mem_rdata;

  assign mem_req   = (state_q == S_REQ);
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

  // Next-state logic: accept/arbitrate in IDLE, hold the request in REQ,
  // and on the response either refill from the pending slot or go idle.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_gnt_d   = last_gnt_q;
    kill_d       = kill_q;
    pend_v_d     = pend_v_q;
    pend_owner_d = pend_owner_q;
    pend_wr_d    = pend_wr_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    pend_wstrb_d = pend_wstrb_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;

    if (pend_drop) begin
      pend_v_d = 1'b0;
    end
    if (flush && (owner_q == OWN_INST) && (state_q != S_IDLE)) begin
      kill_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (inst_take || data_take) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
          if (pick_data) begin
            owner_d     = OWN_DATA;
            last_gnt_d  = OWN_DATA;
            mem_wr_d    = data_wr;
            mem_addr_d  = data_addr;
            mem_wdata_d = data_wdata;
            mem_wstrb_d = data_wstrb;
          end else begin
            owner_d     = OWN_INST;
            last_gnt_d  = OWN_INST;
            mem_wr_d    = 1'b0;
            mem_addr_d  = inst_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
          end
          if (inst_take && data_take) begin
            pend_v_d = 1'b1;
            if (pick_data) begin
              pend_owner_d = OWN_INST;
              pend_wr_d    = 1'b0;
              pend_addr_d  = inst_addr;
              pend_wdata_d = '0;
              pend_wstrb_d = '0;
            end else begin
              pend_owner_d = OWN_DATA;
              pend_wr_d    = data_wr;
              pend_addr_d  = data_addr;
              pend_wdata_d = data_wdata;
              pend_wstrb_d = data_wstrb;
            end
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_resp) begin
          kill_d   = 1'b0;
          pend_v_d = 1'b0;
          if (pend_v_q && !pend_drop) begin
            state_d     = S_REQ;
            owner_d     = pend_owner_q;
            last_gnt_d  = pend_owner_q;
            mem_wr_d    = pend_wr_q;
            mem_addr_d  = pend_addr_q;
            mem_wdata_d = pend_wdata_q;
            mem_wstrb_d = pend_wstrb_q;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and payload registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_INST;
      last_gnt_q   <= OWN_INST;
      kill_q       <= 1'b0;
      pend_v_q     <= 1'b0;
      pend_owner_q <= OWN_INST;
      pend_wr_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      pend_wstrb_q <= '0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_gnt_q   <= last_gnt_d;
      kill_q       <= kill_d;
      pend_v_q     <= pend_v_d;
      pend_owner_q <= pend_owner_d;
      pend_wr_q    <= pend_wr_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      pend_wstrb_q <= pend_wstrb_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041752_mem_arbiter.sv
// Testbench for ysyx_22041752_mem_arbiter.
// The reference model keeps the arbiter's work as a queue of transactions:
// entry 0 is the one on the memory port, entry 1 the parked loser of a tie.
module tb_ysyx_22041752_mem_arbiter;

  localparam bit INST = 1'b0;
  localparam bit DATA = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic        inst_ready, inst_rvalid;
  logic [63:0] inst_rdata;
  logic        data_en, data_wr;
  logic [31:0] data_addr;
  logic [63:0] data_wdata;
  logic [7:0]  data_wstrb;
  logic        data_ready, data_rvalid;
  logic [63:0] data_rdata;
  logic        flush;
  logic        mem_req, mem_wr;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_gnt, mem_resp;
  logic [63:0] mem_rdata;

  ysyx_22041752_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_ready(inst_ready),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_en(data_en), .data_wr(data_wr), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_ready(data_ready),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .flush(flush),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          own;
    bit          wr;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    bit          granted;
    bit          killed;
  } txn_t;

  txn_t        q[$];
  bit          lastData;
  bit          memOut;
  int          memMode;
  logic        sReq;
  logic [31:0] sAddr;
  logic [3:0]  issueLog[$];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    lastData = INST;
    memOut   = 1'b0;
  endtask

  function automatic txn_t mkInst();
    txn_t t;
    t.own = INST; t.wr = 1'b0; t.addr = inst_addr; t.wdata = '0; t.wstrb = '0;
    t.granted = 1'b0; t.killed = 1'b0;
    return t;
  endfunction

  function automatic txn_t mkData();
    txn_t t;
    t.own = DATA; t.wr = data_wr; t.addr = data_addr; t.wdata = data_wdata;
    t.wstrb = data_wstrb; t.granted = 1'b0; t.killed = 1'b0;
    return t;
  endfunction

  // Advance the model across one rising edge using the inputs of the cycle.
  task automatic modelUpdate();
    if (!reset) begin
      modelReset();
      return;
    end
    if (q.size() > 0) begin
      if (flush && q[0].own == INST) q[0].killed = 1'b1;
      if (q.size() > 1 && flush && q[1].own == INST) q.delete(1);
      if (q[0].granted && mem_resp) begin
        void'(q.pop_front());
        if (q.size() > 0) lastData = q[0].own;
      end else if (!q[0].granted && mem_gnt) begin
        q[0].granted = 1'b1;
      end
    end else if (inst_en && data_en) begin
      if (lastData == INST) begin
        q.push_back(mkData()); q.push_back(mkInst()); lastData = DATA;
      end else begin
        q.push_back(mkInst()); q.push_back(mkData()); lastData = INST;
      end
    end else if (data_en) begin
      q.push_back(mkData()); lastData = DATA;
    end else if (inst_en) begin
      q.push_back(mkInst()); lastData = INST;
    end
  endtask

  // Compare every observable output with what the model requires now.
  task automatic checkOutput();
    bit busy, expReq, expIR, expDR;
    sReq  = mem_req;
    sAddr = mem_addr;
    if (!reset) begin
      chk("rst_inst_ready", inst_ready, 0);
      chk("rst_data_ready", data_ready, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_inst_rvalid", inst_rvalid, 0);
      chk("rst_data_rvalid", data_rvalid, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_wstrb", mem_wstrb, 0);
      return;
    end
    busy   = q.size() > 0;
    expReq = busy && !q[0].granted;
    expIR  = busy && q[0].granted && mem_resp && q[0].own == INST && !q[0].killed && !flush;
    expDR  = busy && q[0].granted && mem_resp && q[0].own == DATA;
    chk("inst_ready", inst_ready, !busy);
    chk("data_ready", data_ready, !busy);
    chk("mem_req", mem_req, expReq);
    chk("inst_rvalid", inst_rvalid, expIR);
    chk("data_rvalid", data_rvalid, expDR);
    if (expReq) begin
      chk("mem_addr", mem_addr, q[0].addr);
      chk("mem_wr", mem_wr, q[0].wr);
      if (q[0].wr) begin
        chk("mem_wdata", mem_wdata, q[0].wdata);
        chk("mem_wstrb", mem_wstrb, q[0].wstrb);
      end
    end
    if (expIR) chk("inst_rdata", inst_rdata, mem_rdata);
    if (expDR && !q[0].wr) chk("data_rdata", data_rdata, mem_rdata);
  endtask

  task automatic settle();
    #1;
    checkOutput();
  endtask

  task automatic tick();
    @(posedge clk);
    modelUpdate();
    if (!reset) memOut = 1'b0;
    else begin
      if (mem_resp && memOut) memOut = 1'b0;
      if (sReq && mem_gnt) begin
        memOut = 1'b1;
        issueLog.push_back(sAddr[31:28]);
      end
    end
    @(negedge clk);
    if (memMode == 1) begin
      mem_gnt   = mem_req;
      mem_resp  = memOut;
      mem_rdata = {$urandom, $urandom};
    end
  endtask

  task automatic applyStimulus(input bit ie, input logic [31:0] ia, input bit de,
                               input bit dw, input logic [31:0] da,
                               input logic [63:0] dwd, input logic [7:0] dst,
                               input bit fl);
    inst_en = ie; inst_addr = ia; data_en = de; data_wr = dw; data_addr = da;
    data_wdata = dwd; data_wstrb = dst; flush = fl;
  endtask

  task automatic idleInputs();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic setMem(input bit g, input bit r, input logic [63:0] rd);
    mem_gnt = g; mem_resp = r; mem_rdata = rd;
  endtask

  initial begin
    bit done;
    logic [3:0] rrExp;
    reset = 1'b0;
    memMode = 0;
    idleInputs();
    setMem(0, 0, 0);
    modelReset();

    @(negedge clk);
    settle(); tick();
    settle(); tick();
    reset = 1'b1;
    settle();
    chk("ready_after_release", {inst_ready, data_ready}, 2'b11);
    tick();

    // Single fetch
    applyStimulus(1, 32'h8000_0000, 0, 0, 0, 0, 0, 0);
    settle(); chk("sf_ready_T", inst_ready, 1); tick();
    idleInputs(); setMem(1, 0, 0);
    settle(); chk("sf_req_T1", mem_req, 1); chk("sf_addr_T1", mem_addr, 32'h8000_0000); tick();
    setMem(0, 0, 0);
    settle(); chk("sf_req_T2", mem_req, 0); chk("sf_rvalid_T2", inst_rvalid, 0); tick();
    setMem(0, 1, 64'h0000_0013_0000_0093);
    settle(); chk("sf_rvalid_T3", inst_rvalid, 1);
    chk("sf_rdata_T3", inst_rdata, 64'h0000_0013_0000_0093); tick();
    setMem(0, 0, 0);
    settle(); chk("sf_ready_T4", inst_ready, 1); tick();

    // Tie: data first, fetch straight after with no idle gap
    applyStimulus(1, 32'h8000_0004, 1, 0, 32'h8000_1000, 0, 0, 0);
    settle(); tick();
    idleInputs(); setMem(1, 0, 0);
    settle(); chk("tie_first_addr", mem_addr, 32'h8000_1000); tick();
    setMem(0, 1, 64'hAAAA_0000_BBBB_0001);
    settle(); chk("tie_data_rvalid", data_rvalid, 1); chk("tie_no_inst", inst_rvalid, 0); tick();
    setMem(1, 0, 0);
    settle(); chk("tie_no_gap_req", mem_req, 1); chk("tie_second_addr", mem_addr, 32'h8000_0004); tick();
    setMem(0, 1, 64'h1234);
    settle(); chk("tie_inst_rvalid", inst_rvalid, 1); tick();
    setMem(0, 0, 0);
    settle(); tick();

    // Round-robin over four ties
    issueLog.delete();
    memMode = 1;
    setMem(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 32'h8000_0000 + 32'(k * 4), 1, 0, 32'h9000_0000 + 32'(k * 8), 0, 0, 0);
      settle(); tick();
      idleInputs();
      done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
        settle();
        if (inst_ready) done = 1; else tick();
      end
      chk("rr_drain_in_time", done, 1);
      tick();
    end
    chk("rr_issue_count", issueLog.size(), 8);
    for (int k = 0; k < 8; k++) begin
      rrExp = (k % 2 == 0) ? 4'h9 : 4'h8;
      if (k < issueLog.size()) chk($sformatf("rr_order_%0d", k), issueLog[k], rrExp);
    end
    memMode = 0;
    setMem(0, 0, 0);

    // Store held across three cycles without grant
    applyStimulus(0, 0, 1, 1, 32'h8000_2000, 64'h1122_3344, 8'h0F, 0);
    settle(); tick();
    idleInputs();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("st_req", mem_req, 1); chk("st_wr", mem_wr, 1);
      chk("st_wdata", mem_wdata, 64'h1122_3344); chk("st_wstrb", mem_wstrb, 8'h0F);
      tick();
    end
    setMem(1, 0, 0); settle(); tick();
    setMem(0, 1, 0); settle(); chk("st_ack", data_rvalid, 1); tick();
    setMem(0, 0, 0); settle(); tick();

    // Flush during a fetch's wait, redirect accepted afterwards with flush
    applyStimulus(1, 32'h8000_0100, 0, 0, 0, 0, 0, 0);
    settle(); tick();
    idleInputs(); setMem(1, 0, 0); settle(); tick();
    applyStimulus(1, 32'h8000_0200, 0, 0, 0, 0, 0, 1); setMem(0, 0, 0);
    settle(); chk("fl_not_ready", inst_ready, 0); tick();
    flush = 0; setMem(0, 1, 64'hDEAD);
    settle(); chk("fl_killed_resp", inst_rvalid, 0); tick();
    flush = 1; setMem(0, 0, 0);
    settle(); chk("fl_redirect_ready", inst_ready, 1); tick();
    idleInputs(); setMem(1, 0, 0);
    settle(); chk("fl_redirect_addr", mem_addr, 32'h8000_0200); tick();
    setMem(0, 1, 64'hBEEF);
    settle(); chk("fl_redirect_rvalid", inst_rvalid, 1); tick();
    setMem(0, 0, 0); settle(); tick();

    // Flush drops a parked fetch with no memory access
    applyStimulus(1, 32'h8000_0300, 1, 0, 32'h8000_3000, 0, 0, 0);
    settle(); tick();
    idleInputs(); flush = 1; setMem(1, 0, 0); settle(); tick();
    flush = 0; setMem(0, 1, 64'h55);
    settle(); chk("drop_data_rvalid", data_rvalid, 1); tick();
    setMem(0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      settle(); chk("drop_no_req", mem_req, 0); chk("drop_ready", inst_ready, 1); tick();
    end

    // Reset asserted while waiting for a response
    applyStimulus(1, 32'h8000_0400, 0, 0, 0, 0, 0, 0);
    settle(); tick();
    idleInputs(); setMem(1, 0, 0); settle(); tick();
    setMem(0, 1, 64'h77); reset = 1'b0;
    settle(); chk("rst_mid_rvalid", inst_rvalid, 0); chk("rst_mid_req", mem_req, 0); tick();
    setMem(0, 0, 0); reset = 1'b1;
    settle(); chk("rst_mid_ready", {inst_ready, data_ready}, 2'b11); tick();

    // Randomised traffic against the model
    memMode = 2;
    for (int n = 0; n < 3000; n++) begin
      inst_en    = ($urandom_range(0, 1) == 1);
      inst_addr  = $urandom & 32'hFFFF_FFFC;
      data_en    = ($urandom_range(0, 2) == 0);
      data_wr    = ($urandom_range(0, 1) == 1);
      data_addr  = $urandom & 32'hFFFF_FFF8;
      data_wdata = {$urandom, $urandom};
      data_wstrb = 8'($urandom);
      mem_gnt    = mem_req && ($urandom_range(0, 2) != 0);
      mem_resp   = memOut ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      mem_rdata  = {$urandom, $urandom};
      flush      = !mem_resp && ($urandom_range(0, 7) == 0);
      settle(); tick();
    end

    // Drain whatever is in flight
    idleInputs();
    memMode = 1;
    mem_gnt = mem_req; mem_resp = memOut;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      settle();
      if (inst_ready && q.size() == 0) done = 1; else tick();
    end
    chk("final_drain", done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
